// File: rtl/inst_encoder_loader_pkg.sv
// Shared RV32I encoder definitions: format codes, opcodes, field bundle and
// an immediate sign-extension range helper.
package inst_encoder_loader_pkg;

  localparam int unsigned FMT_WIDTH = 3;
  localparam int unsigned XLEN      = 32;

  typedef enum logic [FMT_WIDTH-1:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } inst_fmt_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [FMT_WIDTH-1:0] fmt;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [XLEN-1:0]      imm;
  } inst_fields_t;

  // True when imm[31:lsb] are all equal, i.e. imm fits a field sign-extended from bit lsb.
  function automatic logic sext_fits(input logic [XLEN-1:0] imm, input int unsigned lsb);
    logic [XLEN-1:0] sh;
    sh = XLEN'($signed(imm) >>> lsb);
    return (&sh) | ~(|sh);
  endfunction

endpackage

// File: rtl/inst_encoder_loader_field_pack.sv
// Combinational RV32I field packer: format + fields -> instruction word and
// a legality flag for the immediate/format combination.
module inst_encoder_loader_field_pack
  import inst_encoder_loader_pkg::*;
(
  input  inst_fields_t    fields_i,
  output logic [XLEN-1:0] code_c,
  output logic            legal_c
);

  logic [XLEN-1:0] imm;
  logic [6:0]      op;
  logic [2:0]      f3;

  assign imm = fields_i.imm;
  assign op  = fields_i.opcode;
  assign f3  = fields_i.funct3;

  always_comb begin
    code_c  = '0;
    legal_c = 1'b0;
    case (fields_i.fmt)
      FMT_R: begin
        code_c  = {fields_i.funct7, fields_i.rs2, fields_i.rs1, f3, fields_i.rd, op};
        legal_c = 1'b1;
      end
      FMT_I: begin
        code_c  = {imm[11:0], fields_i.rs1, f3, fields_i.rd, op};
        legal_c = sext_fits(imm, 11);
      end
      FMT_S: begin
        code_c  = {imm[11:5], fields_i.rs2, fields_i.rs1, f3, imm[4:0], op};
        legal_c = sext_fits(imm, 11);
      end
      FMT_B: begin
        code_c  = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1, f3,
                   imm[4:1], imm[11], op};
        legal_c = sext_fits(imm, 12) & ~imm[0];
      end
      FMT_U: begin
        code_c  = {imm[31:12], fields_i.rd, op};
        legal_c = ~(|imm[11:0]);
      end
      FMT_J: begin
        code_c  = {imm[20], imm[10:1], imm[11], imm[19:12], fields_i.rd, op};
        legal_c = sext_fits(imm, 20) & ~imm[0];
      end
      default: begin
        code_c  = '0;
        legal_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// Instruction-memory loader: encodes accepted RV32I field bundles and streams
// {address, word} writes within a start/done load session.
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_code,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  out_addr_q, out_addr_d;
  logic [31:0]  out_code_q, out_code_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic [31:0]  err_addr_q, err_addr_d;

  inst_fields_t fields;
  logic [31:0]  code;
  logic         legal;
  logic         fire;
  logic [CNT_W-1:0] cnt_inc;

  assign fields = '{fmt: in_fmt, opcode: in_opcode, funct3: in_funct3, funct7: in_funct7,
                    rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  inst_encoder_loader_field_pack u_pack (
    .fields_i (fields),
    .code_c   (code),
    .legal_c  (legal)
  );

  assign in_ready = (state_q == ST_LOAD) & (~out_valid_q | out_ready)
                  & (cnt_q < CNT_W'(DEPTH));
  assign fire     = in_valid & in_ready;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Next-state and session bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_code_d  = out_code_q;
    done_d      = done_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_LOAD;
          addr_d     = BASE_ADDR;
          cnt_d      = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_addr_d = '0;
        end
      end
      ST_LOAD: begin
        if (start) begin
          // Restart abandons the in-flight word along with the session state.
          addr_d      = BASE_ADDR;
          cnt_d       = '0;
          done_d      = 1'b0;
          err_d       = 1'b0;
          err_addr_d  = '0;
          out_valid_d = 1'b0;
        end else if (fire) begin
          if (legal) begin
            out_valid_d = 1'b1;
            out_addr_d  = addr_q;
            out_code_d  = code;
            addr_d      = addr_q + 32'd4;
            cnt_d       = cnt_inc;
          end else begin
            err_d = 1'b1;
            if (!err_q) begin
              err_addr_d = addr_q;
            end
          end
          if (in_last || (legal && (cnt_inc == CNT_W'(DEPTH)))) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= BASE_ADDR;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= BASE_ADDR;
      out_code_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_code_q  <= out_code_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_code  = out_code_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign busy      = (state_q == ST_LOAD) | out_valid_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Scenario bench for inst_encoder_loader: expected writes are queued as bundles
// are sent and compared when the DUT completes each imem write.
module tb_inst_encoder_loader;
  import inst_encoder_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready, in_last;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_addr, out_code, err_addr;
  logic        busy, done, err;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] code;
  } wr_t;

  wr_t         sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_addr = 32'h0;

  always #5 clk = ~clk;

  inst_encoder_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_code(out_code), .busy(busy), .done(done),
    .err(err), .err_addr(err_addr)
  );

  // Completed imem writes are checked against the queued expectations.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h code=%h", out_addr, out_code);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        if (out_addr !== e.addr || out_code !== e.code) begin
          bad++;
          $display("FAIL write got addr=%h code=%h exp addr=%h code=%h",
                   out_addr, out_code, e.addr, e.code);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic inst_fields_t mk(input logic [2:0] fmt, input logic [6:0] op,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [31:0] imm);
    return '{fmt: fmt, opcode: op, funct3: f3, funct7: f7, rd: rd, rs1: rs1, rs2: rs2, imm: imm};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = 32'h0;
  endtask

  // Offer one bundle and wait for acceptance; legal pushes its expected write.
  task automatic send(input inst_fields_t f, input logic last, input logic exp_legal,
                      input logic [31:0] exp_code, input logic push, output int waited);
    in_fmt = f.fmt; in_opcode = f.opcode; in_funct3 = f.funct3; in_funct7 = f.funct7;
    in_rd = f.rd; in_rs1 = f.rs1; in_rs2 = f.rs2; in_imm = f.imm;
    in_last = last; in_valid = 1'b1;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout got in_ready=%b exp 1", in_ready);
      in_valid = 1'b0; in_last = 1'b0;
      return;
    end
    if (exp_legal && push) sb_q.push_back('{addr: exp_addr, code: exp_code});
    if (exp_legal) exp_addr = exp_addr + 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_fmt = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, busy, done, err} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {in_ready, out_valid, busy, done, err});
    end
    total++;
    if (out_addr !== 32'h0 || out_code !== 32'h0 || err_addr !== 32'h0) begin
      bad++; $display("FAIL reset_regs got addr=%h code=%h err_addr=%h exp 0", out_addr, out_code, err_addr);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_ready got in_ready=%b busy=%b exp 0 0", in_ready, busy);
    end
  endtask

  task automatic test_i_format();
    int w;
    pulse_start();
    out_ready = 1'b1;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL load_ready got in_ready=%b busy=%b exp 1 1", in_ready, busy);
    end
    send(mk(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd2, 5'd1, 5'd0, -32'sd241), 1'b0, 1'b1, 32'hF0F08113, 1'b1, w);
    total++;
    if (out_valid !== 1'b1 || out_addr !== 32'h0 || out_code !== 32'hF0F08113) begin
      bad++; $display("FAIL i_latency got v=%b addr=%h code=%h exp 1 0 F0F08113", out_valid, out_addr, out_code);
    end
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    send(mk(FMT_S, OPC_STORE, 3'd0, 7'd0, 5'd0, 5'd2, 5'd1, -32'sd32), 1'b0, 1'b1, 32'hFE110023, 1'b1, w1);
    send(mk(FMT_B, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd2218), 1'b0, 1'b1, 32'h0A2085E3, 1'b1, w2);
    total++;
    if (w1 != 0 || w2 != 0) begin
      bad++; $display("FAIL b2b_stall got waits=%0d,%0d exp 0,0", w1, w2);
    end
    total++;
    if (out_addr !== 32'h8 || out_code !== 32'h0A2085E3) begin
      bad++; $display("FAIL b_word got addr=%h code=%h exp 8 0A2085E3", out_addr, out_code);
    end
  endtask

  task automatic test_j_last();
    int w;
    send(mk(FMT_J, OPC_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd1046528), 1'b1, 1'b1, 32'h801000EF, 1'b1, w);
    total++;
    if (done !== 1'b1 || in_ready !== 1'b0 || out_code !== 32'h801000EF) begin
      bad++; $display("FAIL j_done got done=%b in_ready=%b code=%h exp 1 0 801000EF", done, in_ready, out_code);
    end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL after_done got in_ready=%b v=%b busy=%b done=%b exp 0 0 0 1", in_ready, out_valid, busy, done);
    end
  endtask

  task automatic test_backpressure();
    int w;
    int held;
    pulse_start();
    out_ready = 1'b0;
    send(mk(FMT_U, OPC_LUI, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hF0F0F000), 1'b0, 1'b1, 32'hF0F0F0B7, 1'b1, w);
    held = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (in_ready === 1'b0 && out_valid === 1'b1 && out_code === 32'hF0F0F0B7 && out_addr === 32'h0) held++;
    end
    total++;
    if (held != 3) begin
      bad++; $display("FAIL u_hold got stable_cycles=%0d exp 3", held);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL u_drain got v=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_illegal();
    int w;
    send(mk(FMT_B, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3), 1'b0, 1'b0, 32'h0, 1'b0, w);
    total++;
    if (err !== 1'b1 || err_addr !== 32'h4 || out_valid !== 1'b0) begin
      bad++; $display("FAIL ill_b got err=%b err_addr=%h v=%b exp 1 4 0", err, err_addr, out_valid);
    end
    send(mk(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd2048), 1'b0, 1'b0, 32'h0, 1'b0, w);
    total++;
    if (err !== 1'b1 || err_addr !== 32'h4 || out_valid !== 1'b0) begin
      bad++; $display("FAIL ill_i got err=%b err_addr=%h v=%b exp 1 4 0", err, err_addr, out_valid);
    end
    send(mk(FMT_R, OPC_OP, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0), 1'b0, 1'b1, 32'h002081B3, 1'b1, w);
    total++;
    if (out_addr !== 32'h4 || out_code !== 32'h002081B3) begin
      bad++; $display("FAIL r_after_err got addr=%h code=%h exp 4 002081B3", out_addr, out_code);
    end
    send(mk(3'd7, OPC_OP, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0), 1'b1, 1'b0, 32'h0, 1'b0, w);
    total++;
    if (done !== 1'b1 || err !== 1'b1 || err_addr !== 32'h4 || in_ready !== 1'b0) begin
      bad++; $display("FAIL ill_last got done=%b err=%b err_addr=%h in_ready=%b exp 1 1 4 0", done, err, err_addr, in_ready);
    end
  endtask

  task automatic test_depth();
    int w;
    int seen;
    pulse_start();
    total++;
    if (err !== 1'b0 || done !== 1'b0 || err_addr !== 32'h0) begin
      bad++; $display("FAIL start_clear got err=%b done=%b err_addr=%h exp 0 0 0", err, done, err_addr);
    end
    send(mk(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1), 1'b0, 1'b1, 32'h00100093, 1'b1, w);
    send(mk(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2), 1'b0, 1'b1, 32'h00200093, 1'b1, w);
    send(mk(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3), 1'b0, 1'b1, 32'h00300093, 1'b1, w);
    send(mk(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4), 1'b0, 1'b1, 32'h00400093, 1'b1, w);
    total++;
    if (done !== 1'b1 || in_ready !== 1'b0 || out_addr !== 32'hC) begin
      bad++; $display("FAIL depth_done got done=%b in_ready=%b addr=%h exp 1 0 C", done, in_ready, out_addr);
    end
    in_fmt = FMT_I; in_imm = 32'd5; in_valid = 1'b1;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0) seen++;
    end
    in_valid = 1'b0;
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL fifth_accepted got ready_cycles=%0d exp 0", seen);
    end
  endtask

  task automatic test_restart();
    int w;
    pulse_start();
    out_ready = 1'b0;
    send(mk(FMT_B, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3), 1'b0, 1'b0, 32'h0, 1'b0, w);
    send(mk(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7), 1'b0, 1'b1, 32'h00700093, 1'b0, w);
    total++;
    if (err !== 1'b1 || out_valid !== 1'b1) begin
      bad++; $display("FAIL pre_restart got err=%b v=%b exp 1 1", err, out_valid);
    end
    pulse_start();
    total++;
    if (out_valid !== 1'b0 || err !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      bad++; $display("FAIL restart got v=%b err=%b done=%b busy=%b in_ready=%b exp 0 0 0 1 1",
                      out_valid, err, done, busy, in_ready);
    end
    out_ready = 1'b1;
    send(mk(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1), 1'b0, 1'b1, 32'h00100093, 1'b1, w);
    total++;
    if (out_addr !== 32'h0 || out_code !== 32'h00100093) begin
      bad++; $display("FAIL restart_addr got addr=%h code=%h exp 0 00100093", out_addr, out_code);
    end
  endtask

  initial begin
    test_reset();
    test_i_format();
    test_back_to_back();
    test_j_last();
    test_backpressure();
    test_illegal();
    test_depth();
    test_restart();
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL missing_writes got pending=%0d exp 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
